// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared Y86 instruction/data memory port: serialises fetch and
// data accesses, holds a registered memory request until ack, flags sticky timeouts.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 48,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  input  logic              m_req_i,
  input  logic              m_we_i,
  input  logic [ADDR_W-1:0] m_addr_i,
  input  logic [DATA_W-1:0] m_wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              f_ack_o,
  output logic [DATA_W-1:0] f_rdata_o,
  output logic              m_ack_o,
  output logic [DATA_W-1:0] m_rdata_o,
  output logic              F_stall_o,
  output logic              M_stall_o,
  output logic              err_o
);

  localparam int unsigned WAIT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {IDLE, F_BUSY, M_BUSY, RESP, ERR} state_t;

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                m_grant;

  // Data wins unless fetch has already waited through STARVE_MAX data grants.
  always_comb begin
    m_grant = m_req_i && (!f_req_i || (starve_cnt < STARVE_W'(STARVE_MAX)));
  end

  assign F_stall_o = f_req_i & ~f_ack_o;
  assign M_stall_o = m_req_i & ~m_ack_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      f_ack_o     <= 1'b0;
      m_ack_o     <= 1'b0;
      f_rdata_o   <= '0;
      m_rdata_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      f_ack_o <= 1'b0;
      m_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (m_grant) begin
            state       <= M_BUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= m_we_i;
            mem_addr_o  <= m_addr_i;
            mem_wdata_o <= m_wdata_i;
            wait_cnt    <= '0;
            starve_cnt  <= f_req_i ? starve_cnt + STARVE_W'(1) : '0;
          end else if (f_req_i) begin
            state       <= F_BUSY;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= f_addr_i;
            mem_wdata_o <= '0;
            wait_cnt    <= '0;
            starve_cnt  <= '0;
          end
        end
        F_BUSY, M_BUSY: begin
          if (mem_ack_i) begin
            if (state == F_BUSY) begin
              f_rdata_o <= mem_rdata_i;
              f_ack_o   <= 1'b1;
            end else begin
              m_rdata_o <= mem_rdata_i;
              m_ack_o   <= 1'b1;
            end
            mem_req_o <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            // This is the TIMEOUT-th BUSY cycle without an ack.
            if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
              state     <= ERR;
              mem_req_o <= 1'b0;
              err_o     <= 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 48;
  localparam int unsigned TIMEOUT    = 15;
  localparam int unsigned STARVE_MAX = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              f_req_i, m_req_i, m_we_i;
  logic [ADDR_W-1:0] f_addr_i, m_addr_i;
  logic [DATA_W-1:0] m_wdata_i, mem_rdata_i;
  logic              mem_req_o, mem_we_o, mem_ack_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o, f_rdata_o, m_rdata_o;
  logic              f_ack_o, m_ack_o, F_stall_o, M_stall_o, err_o;
  logic              ack_force, auto_ack;

  assign mem_ack_i = ack_force | (auto_ack & mem_req_o);

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .f_ack_o(f_ack_o), .f_rdata_o(f_rdata_o), .m_ack_o(m_ack_o), .m_rdata_o(m_rdata_o),
    .F_stall_o(F_stall_o), .M_stall_o(M_stall_o), .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; f_req_i = 0; m_req_i = 0; m_we_i = 0; ack_force = 0; auto_ack = 0;
    f_addr_i = '0; m_addr_i = '0; m_wdata_i = '0; mem_rdata_i = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit f; bit m; bit we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int lat;
    bit f_wins;
    int ack_cyc;
  } vec_t;

  vec_t vecs[5];

  // Transaction-level reference: who owns the port, how long it has waited,
  // pending completion pulse and sticky error.
  int owner, age, lat, starve;
  bit r_f, r_m, e_err, prev_rf, prev_rm;
  logic              e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_frd, e_mrd;

  task automatic model_clear();
    owner = 0; age = 0; lat = 0; starve = 0; r_f = 0; r_m = 0; e_err = 0;
    e_we = 0; e_addr = '0; e_wdata = '0; e_frd = '0; e_mrd = '0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_clear();
    end else if (r_f || r_m) begin
      r_f = 0; r_m = 0;
    end else if (e_err) begin
      e_err = 1;
    end else if (owner != 0) begin
      if (mem_ack_i) begin
        if (owner == 1) e_frd = mem_rdata_i; else e_mrd = mem_rdata_i;
        r_f = (owner == 1); r_m = (owner == 2); owner = 0;
      end else begin
        age++;
        if (age == TIMEOUT) begin e_err = 1; owner = 0; end
      end
    end else begin
      if (m_req_i && (!f_req_i || starve < STARVE_MAX)) begin
        owner = 2; e_we = m_we_i; e_addr = m_addr_i; e_wdata = m_wdata_i;
        starve = f_req_i ? starve + 1 : 0;
      end else if (f_req_i) begin
        owner = 1; e_we = 0; e_addr = f_addr_i; e_wdata = '0; starve = 0;
      end
      if (owner != 0) begin
        age = 0;
        lat = ($urandom_range(0, 99) == 0) ? 30 : int'($urandom_range(0, 4));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int got, n, pulses, prev;
    vecs[0] = '{f:1, m:0, we:0, addr:32'h100, wdata:48'h0, rdata:48'h30F2_0A00_0000, lat:0, f_wins:1, ack_cyc:2};
    vecs[1] = '{f:0, m:1, we:1, addr:32'h200, wdata:48'h1234, rdata:48'hDEAD, lat:3, f_wins:0, ack_cyc:5};
    vecs[2] = '{f:0, m:1, we:0, addr:32'h3C, wdata:48'h77, rdata:48'hABCDEF, lat:1, f_wins:0, ack_cyc:3};
    vecs[3] = '{f:1, m:1, we:1, addr:32'h80, wdata:48'h5A5A, rdata:48'h1, lat:0, f_wins:0, ack_cyc:2};
    vecs[4] = '{f:1, m:0, we:0, addr:32'hFFC, wdata:48'h0, rdata:48'h0102_0304_0506, lat:14, f_wins:1, ack_cyc:16};

    // Reset state, with stalls following the requests while rst is high
    rst = 1'b1; f_req_i = 1; m_req_i = 0; m_we_i = 0; ack_force = 1; auto_ack = 0;
    f_addr_i = 32'h40; m_addr_i = '0; m_wdata_i = '0; mem_rdata_i = 48'hFFFF;
    tick(); tick();
    chk("reset_outputs", {mem_req_o, mem_we_o, f_ack_o, m_ack_o, err_o}, 5'b0);
    chk("reset_data", {mem_addr_o, mem_wdata_o, f_rdata_o, m_rdata_o} == '0, 1'b1);
    chk("reset_stall", {F_stall_o, M_stall_o}, 2'b10);

    for (int i = 0; i < 5; i++) begin
      vec_t v;
      logic [ADDR_W-1:0] xa;
      v = vecs[i];
      do_reset();
      f_req_i = v.f; m_req_i = v.m; f_addr_i = v.addr; m_addr_i = v.addr + 32'h40;
      m_we_i = v.we; m_wdata_i = v.wdata; mem_rdata_i = v.rdata;
      xa = v.f_wins ? v.addr : v.addr + 32'h40;
      #1 chk("vec_stall_c0", {F_stall_o, M_stall_o}, {v.f, v.m});
      got = 0;
      for (int c = 1; c <= 40 && got == 0; c++) begin
        tick();
        ack_force = (c == 1 + v.lat);
        #1;
        if (c <= 1 + v.lat) chk($sformatf("vec%0d_memreq_c%0d", i, c), mem_req_o, 1'b1);
        if (c == 1) begin
          chk($sformatf("vec%0d_addr", i), mem_addr_o, xa);
          chk($sformatf("vec%0d_we", i), mem_we_o, v.f_wins ? 1'b0 : v.we);
          chk($sformatf("vec%0d_wdata", i), mem_wdata_o, v.f_wins ? '0 : v.wdata);
        end
        if (f_ack_o || m_ack_o) begin
          got = c;
          chk($sformatf("vec%0d_ack_cycle", i), c, v.ack_cyc);
          chk($sformatf("vec%0d_ack_which", i), {f_ack_o, m_ack_o}, v.f_wins ? 2'b10 : 2'b01);
          chk($sformatf("vec%0d_rdata", i), v.f_wins ? f_rdata_o : m_rdata_o, v.rdata);
          chk($sformatf("vec%0d_stall_ack", i), {F_stall_o, M_stall_o}, v.f_wins ? {1'b0, v.m} : {v.f, 1'b0});
          chk($sformatf("vec%0d_memreq_ack", i), mem_req_o, 1'b0);
        end
      end
      if (got == 0) chk($sformatf("vec%0d_ack_timeout", i), 0, 1);
      ack_force = 0; f_req_i = 0; m_req_i = 0; mem_rdata_i = '0;
      tick(); tick();
      chk($sformatf("vec%0d_rdata_held", i), v.f_wins ? f_rdata_o : m_rdata_o, v.rdata);
    end

    // Contention: both held, zero-wait memory -> M, M, F repeating
    do_reset();
    f_req_i = 1; m_req_i = 1; f_addr_i = 32'h1000; m_addr_i = 32'h2000; auto_ack = 1;
    n = 0; prev = 0;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (mem_req_o && prev == 0) begin
        chk($sformatf("contend_grant%0d", n), mem_addr_o == 32'h1000, (n % 3) == 2);
        n++;
      end
      prev = mem_req_o;
    end
    chk("contend_grant_count", n, 6);
    auto_ack = 0;

    // Timeout on a fetch that memory never answers
    do_reset();
    f_req_i = 1; f_addr_i = 32'h500;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 15) chk("tmo_busy15", {mem_req_o, err_o}, 2'b10);
      if (c == 16) chk("tmo_err", {mem_req_o, err_o, F_stall_o}, 3'b011);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      ack_force = (k == 0);
      #1;
      chk($sformatf("tmo_late_ack%0d", k), {f_ack_o, err_o, mem_req_o}, 3'b010);
    end
    ack_force = 0; rst = 1;
    tick();
    chk("tmo_rst_clears", {err_o, F_stall_o}, 2'b01);
    rst = 0; f_req_i = 0;

    // Reset pulsed in M_BUSY, stale ack the cycle after
    do_reset();
    m_req_i = 1; m_we_i = 1; m_addr_i = 32'h600; m_wdata_i = 48'h4444;
    tick();
    chk("rstmid_busy", mem_req_o, 1'b1);
    rst = 1;
    tick();
    rst = 0; m_req_i = 0; m_we_i = 0; ack_force = 1; mem_rdata_i = 48'h9999;
    #1 chk("rstmid_outputs", {mem_req_o, mem_we_o, m_ack_o, err_o, mem_addr_o == '0, mem_wdata_o == '0}, 6'b000011);
    tick();
    ack_force = 0;
    #1 chk("rstmid_no_ack", {m_ack_o, mem_req_o, m_rdata_o == '0}, 3'b001);
    m_req_i = 1; m_addr_i = 32'h900; mem_rdata_i = 48'h55; auto_ack = 1;
    got = 0;
    for (int c = 1; c <= 10 && got == 0; c++) begin
      tick();
      if (m_ack_o) begin
        got = c;
        chk("rstmid_next_cycle", c, 2);
        chk("rstmid_next_rdata", m_rdata_o, 48'h55);
      end
    end
    if (got == 0) chk("rstmid_next_timeout", 0, 1);
    auto_ack = 0; m_req_i = 0;

    // Fetch request dropped the cycle after its grant
    do_reset();
    f_req_i = 1; f_addr_i = 32'h700;
    tick();
    f_req_i = 0;
    #1 chk("drop_stall", {F_stall_o, mem_req_o}, 2'b01);
    pulses = 0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      ack_force = (c == 2);
      #1;
      if (f_ack_o) pulses++;
      if (c == 3) chk("drop_ack_c3", f_ack_o, 1'b1);
      chk($sformatf("drop_stall_c%0d", c), F_stall_o, 1'b0);
    end
    chk("drop_pulses", pulses, 1);
    ack_force = 0;

    // Randomized traffic against the reference model
    do_reset();
    model_clear();
    prev_rf = 0; prev_rm = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      rst = e_err ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 399) == 0);
      if (!f_req_i || prev_rf) begin
        f_req_i = $urandom_range(0, 1);
        f_addr_i = $urandom();
      end
      if (!m_req_i || prev_rm) begin
        m_req_i = $urandom_range(0, 1);
        m_we_i = $urandom_range(0, 1);
        m_addr_i = $urandom();
        m_wdata_i = DATA_W'({$urandom(), $urandom()});
      end
      ack_force = (owner != 0) ? (age == lat) : ($urandom_range(0, 5) == 0);
      mem_rdata_i = DATA_W'({$urandom(), $urandom()});
      #2;
      chk("rnd_memreq", mem_req_o, owner != 0);
      chk("rnd_addr", mem_addr_o, e_addr);
      chk("rnd_we", mem_we_o, e_we);
      chk("rnd_wdata", mem_wdata_o, e_wdata);
      chk("rnd_acks", {f_ack_o, m_ack_o, err_o}, {r_f, r_m, e_err});
      chk("rnd_frdata", f_rdata_o, e_frd);
      chk("rnd_mrdata", m_rdata_o, e_mrd);
      chk("rnd_stalls", {F_stall_o, M_stall_o}, {f_req_i & ~r_f, m_req_i & ~r_m});
      prev_rf = r_f; prev_rm = r_m;
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
